// File: rtl/video_rx_monitor.sv
// Sink-side pixel stream checker: measures line/frame geometry, sums pixel data per frame
// and asserts lock once enough consecutive frames match the configured resolution.
module video_rx_monitor #(
    parameter int unsigned H_RES       = 1024,
    parameter int unsigned V_RES       = 768,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned SYNC_POL    = 1
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        active,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        frame_done,
    output logic [12:0] meas_htotal,
    output logic [12:0] meas_width,
    output logic [12:0] meas_height,
    output logic [31:0] checksum,
    output logic [15:0] frame_count,
    output logic [15:0] err_count,
    output logic        locked
);

    localparam logic StWaitVsync = 1'b0;
    localparam logic StMeasure   = 1'b1;

    function automatic logic [12:0] sat13(input logic [12:0] v);
        return (v == 13'h1fff) ? v : v + 13'd1;
    endfunction

    logic        hs_q, vs_q, act_q, hs_qq, vs_qq, act_qq;
    logic [23:0] pix_q, pix_ev_q;
    logic        hs_ev_q, vs_ev_q, fall_ev_q, rise_ev_q, act_ev_q;
    logic [12:0] hcnt_q, htotal_q;

    logic        state_q, state_d;
    logic [12:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, ref_width_q, ref_width_d;
    logic        incons_q, incons_d, line_open_q, line_open_d;
    logic [31:0] csum_q, csum_d;
    logic        done_q, done_d, locked_q, locked_d;
    logic [12:0] width_q, width_d, height_q, height_d;
    logic [31:0] chk_q, chk_d;
    logic [15:0] fcount_q, fcount_d, ecount_q, ecount_d;
    logic [3:0]  good_run_q, good_run_d;

    logic        line_close, incons_eff, frame_good;
    logic [12:0] ref_w_eff, lines_eff;

    // Stage 1 registers inputs, stage 2 is the delayed copy, stage 3 holds aligned events.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            act_q     <= 1'b0;
            pix_q     <= '0;
            hs_qq     <= 1'b0;
            vs_qq     <= 1'b0;
            act_qq    <= 1'b0;
            hs_ev_q   <= 1'b0;
            vs_ev_q   <= 1'b0;
            fall_ev_q <= 1'b0;
            rise_ev_q <= 1'b0;
            act_ev_q  <= 1'b0;
            pix_ev_q  <= '0;
        end else begin
            hs_q      <= (SYNC_POL != 0) ? hsync : ~hsync;
            vs_q      <= (SYNC_POL != 0) ? vsync : ~vsync;
            act_q     <= active;
            pix_q     <= {r, g, b};
            hs_qq     <= hs_q;
            vs_qq     <= vs_q;
            act_qq    <= act_q;
            hs_ev_q   <= hs_q & ~hs_qq;
            vs_ev_q   <= vs_q & ~vs_qq;
            fall_ev_q <= act_qq & ~act_q;
            rise_ev_q <= act_q & ~act_qq;
            act_ev_q  <= act_q;
            pix_ev_q  <= pix_q;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q   <= '0;
            htotal_q <= '0;
        end else if (hs_ev_q) begin
            hcnt_q   <= '0;
            htotal_q <= sat13(hcnt_q);
        end else begin
            hcnt_q   <= sat13(hcnt_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        ref_width_d = ref_width_q;
        incons_d    = incons_q;
        line_open_d = line_open_q;
        csum_d      = csum_q;
        done_d      = 1'b0;
        width_d     = width_q;
        height_d    = height_q;
        chk_d       = chk_q;
        fcount_d    = fcount_q;
        ecount_d    = ecount_q;
        good_run_d  = good_run_q;
        locked_d    = locked_q;

        // A line only closes if its start was seen in this frame; the close is folded into
        // the frame result when it coincides with the vsync edge.
        line_close = fall_ev_q & line_open_q;
        ref_w_eff  = (line_close && line_cnt_q == '0) ? pix_cnt_q : ref_width_q;
        incons_eff = incons_q |
                     (line_close && (line_cnt_q != '0) && (pix_cnt_q != ref_width_q));
        lines_eff  = line_close ? sat13(line_cnt_q) : line_cnt_q;
        frame_good = !incons_eff && !act_ev_q &&
                     (32'(ref_w_eff) == H_RES) && (32'(lines_eff) == V_RES);

        if (state_q == StWaitVsync || vs_ev_q) begin
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            ref_width_d = '0;
            incons_d    = 1'b0;
            line_open_d = 1'b0;
            csum_d      = '0;
        end

        if (state_q == StWaitVsync) begin
            if (vs_ev_q) state_d = StMeasure;
        end else if (vs_ev_q) begin
            done_d   = 1'b1;
            width_d  = ref_w_eff;
            height_d = lines_eff;
            chk_d    = csum_q;
            fcount_d = fcount_q + 16'd1;
            if (frame_good) begin
                good_run_d = (good_run_q == 4'hf) ? good_run_q : good_run_q + 4'd1;
                locked_d   = locked_q | (good_run_d == 4'(LOCK_FRAMES));
            end else begin
                good_run_d = '0;
                locked_d   = 1'b0;
                ecount_d   = (ecount_q == 16'hffff) ? ecount_q : ecount_q + 16'd1;
            end
        end else begin
            if (fall_ev_q)     pix_cnt_d = '0;
            else if (act_ev_q) pix_cnt_d = sat13(pix_cnt_q);
            if (rise_ev_q)      line_open_d = 1'b1;
            else if (fall_ev_q) line_open_d = 1'b0;
            if (line_close) begin
                ref_width_d = ref_w_eff;
                incons_d    = incons_eff;
                line_cnt_d  = lines_eff;
            end
            if (act_ev_q) csum_d = csum_q + {8'd0, pix_ev_q};
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitVsync;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            ref_width_q <= '0;
            incons_q    <= 1'b0;
            line_open_q <= 1'b0;
            csum_q      <= '0;
            done_q      <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            chk_q       <= '0;
            fcount_q    <= '0;
            ecount_q    <= '0;
            good_run_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            ref_width_q <= ref_width_d;
            incons_q    <= incons_d;
            line_open_q <= line_open_d;
            csum_q      <= csum_d;
            done_q      <= done_d;
            width_q     <= width_d;
            height_q    <= height_d;
            chk_q       <= chk_d;
            fcount_q    <= fcount_d;
            ecount_q    <= ecount_d;
            good_run_q  <= good_run_d;
            locked_q    <= locked_d;
        end
    end

    assign frame_done  = done_q;
    assign meas_htotal = htotal_q;
    assign meas_width  = width_q;
    assign meas_height = height_q;
    assign checksum    = chk_q;
    assign frame_count = fcount_q;
    assign err_count   = ecount_q;
    assign locked      = locked_q;

endmodule
